nios2core_gpio_arbiter: RTL and testbench

- Two-port Avalon-MM arbiter in front of the 4-word GPIO slave (data at word 0, direction at word 1).
- Lets the Nios II data master (port m0) and a hardware pattern/DMA engine (port m1) share one GPIO instance.
- Round-robin grant, one transaction at a time.
- Handles the slave's fixed one-cycle registered read latency, and returns read data with a readdatavalid pulse.

---
 rtl/nios2core_gpio_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_nios2core_gpio_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2core_gpio_arbiter.sv
// Round-robin two-master Avalon-MM arbiter in front of the 4-word GPIO slave.
// Define NIOS2CORE_GPIO_ARB_BITOP_EN for shadowed atomic bit set (addr 2) / clear (addr 3).
module nios2core_gpio_arbiter #(
   parameter int unsigned GPIO_WIDTH = 28
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  m0_address,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [31:0] m0_writedata,
   output logic        m0_waitrequest,
   output logic [31:0] m0_readdata,
   output logic        m0_readdatavalid,
   input  logic [1:0]  m1_address,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [31:0] m1_writedata,
   output logic        m1_waitrequest,
   output logic [31:0] m1_readdata,
   output logic        m1_readdatavalid,
   output logic [1:0]  s_address,
   output logic        s_chipselect,
   output logic        s_write_n,
   output logic [31:0] s_writedata,
   input  logic [31:0] s_readdata
);

   localparam int unsigned AW = 2;
   localparam int unsigned DW = 32;

   if (GPIO_WIDTH == 0 || GPIO_WIDTH > DW) begin : g_bad_width
      $error("GPIO_WIDTH must be in 1..32");
   end

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WRITE   = 2'd1,
      S_RD_ADDR = 2'd2,
      S_RD_DATA = 2'd3
   } state_t;

   state_t          r_state;
   logic            r_grant;
   logic            r_last_grant;
   logic [AW-1:0]   r_s_address;
   logic            r_s_chipselect;
   logic            r_s_write_n;
   logic [DW-1:0]   r_s_writedata;
   logic            r_m0_waitrequest;
   logic            r_m1_waitrequest;
   logic [DW-1:0]   r_m0_readdata;
   logic [DW-1:0]   r_m1_readdata;
   logic            r_m0_readdatavalid;
   logic            r_m1_readdatavalid;

   logic            w_m0_req;
   logic            w_m1_req;
   logic            w_any_req;
   logic            w_sel;
   logic            w_sel_write;
   logic [AW-1:0]   w_sel_address;
   logic [DW-1:0]   w_sel_writedata;
   logic [AW-1:0]   w_slv_address;
   logic [DW-1:0]   w_slv_writedata;
   logic [DW-1:0]   w_rd_data;

   // Request selection: a lone requester wins, a tie goes to the port not served last.
   assign w_m0_req        = m0_read | m0_write;
   assign w_m1_req        = m1_read | m1_write;
   assign w_any_req       = w_m0_req | w_m1_req;
   assign w_sel           = (w_m0_req && w_m1_req) ? ~r_last_grant : w_m1_req;
   assign w_sel_write     = w_sel ? m1_write     : m0_write;
   assign w_sel_address   = w_sel ? m1_address   : m0_address;
   assign w_sel_writedata = w_sel ? m1_writedata : m0_writedata;

`ifdef NIOS2CORE_GPIO_ARB_BITOP_EN
   logic [GPIO_WIDTH-1:0] r_shadow;
   logic [GPIO_WIDTH-1:0] w_shadow_nxt;

   // Set/clear writes are folded into a plain data write using the shadow of data_out.
   always_comb begin
      w_slv_address   = w_sel_address;
      w_slv_writedata = w_sel_writedata;
      w_shadow_nxt    = r_shadow;
      if (w_sel_write) begin
         case (w_sel_address)
            2'd0:    w_shadow_nxt = w_sel_writedata[GPIO_WIDTH-1:0];
            2'd2:    w_shadow_nxt = r_shadow | w_sel_writedata[GPIO_WIDTH-1:0];
            2'd3:    w_shadow_nxt = r_shadow & ~w_sel_writedata[GPIO_WIDTH-1:0];
            default: w_shadow_nxt = r_shadow;
         endcase
         if (w_sel_address[1]) begin
            w_slv_address   = AW'(0);
            w_slv_writedata = DW'(w_shadow_nxt);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_shadow <= '0;
      end else if (r_state == S_IDLE && w_any_req && w_sel_write) begin
         r_shadow <= w_shadow_nxt;
      end
   end

   // Reads of the set/clear aliases return the shadow instead of the slave data.
   assign w_rd_data = r_s_address[1] ? DW'(r_shadow) : s_readdata;
`else
   assign w_slv_address   = w_sel_address;
   assign w_slv_writedata = w_sel_writedata;
   assign w_rd_data       = s_readdata;
`endif

   // Arbiter FSM; every bus output is a register updated alongside the state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state            <= S_IDLE;
         r_grant            <= 1'b0;
         r_last_grant       <= 1'b1;
         r_s_address        <= '0;
         r_s_chipselect     <= 1'b0;
         r_s_write_n        <= 1'b1;
         r_s_writedata      <= '0;
         r_m0_waitrequest   <= 1'b1;
         r_m1_waitrequest   <= 1'b1;
         r_m0_readdata      <= '0;
         r_m1_readdata      <= '0;
         r_m0_readdatavalid <= 1'b0;
         r_m1_readdatavalid <= 1'b0;
      end else begin
         r_m0_readdatavalid <= 1'b0;
         r_m1_readdatavalid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_grant        <= w_sel;
                  r_last_grant   <= w_sel;
                  r_s_address    <= w_slv_address;
                  r_s_writedata  <= w_slv_writedata;
                  r_s_chipselect <= 1'b1;
                  if (w_sel_write) begin
                     r_state     <= S_WRITE;
                     r_s_write_n <= 1'b0;
                     if (w_sel) r_m1_waitrequest <= 1'b0;
                     else       r_m0_waitrequest <= 1'b0;
                  end else begin
                     r_state     <= S_RD_ADDR;
                     r_s_write_n <= 1'b1;
                  end
               end
            end
            S_WRITE: begin
               r_state          <= S_IDLE;
               r_s_chipselect   <= 1'b0;
               r_s_write_n      <= 1'b1;
               r_m0_waitrequest <= 1'b1;
               r_m1_waitrequest <= 1'b1;
            end
            S_RD_ADDR: begin
               r_state        <= S_RD_DATA;
               r_s_chipselect <= 1'b0;
               if (r_grant) r_m1_waitrequest <= 1'b0;
               else         r_m0_waitrequest <= 1'b0;
            end
            S_RD_DATA: begin
               r_state          <= S_IDLE;
               r_m0_waitrequest <= 1'b1;
               r_m1_waitrequest <= 1'b1;
               if (r_grant) begin
                  r_m1_readdata      <= w_rd_data;
                  r_m1_readdatavalid <= 1'b1;
               end else begin
                  r_m0_readdata      <= w_rd_data;
                  r_m0_readdatavalid <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign s_address        = r_s_address;
   assign s_chipselect     = r_s_chipselect;
   assign s_write_n        = r_s_write_n;
   assign s_writedata      = r_s_writedata;
   assign m0_waitrequest   = r_m0_waitrequest;
   assign m1_waitrequest   = r_m1_waitrequest;
   assign m0_readdata      = r_m0_readdata;
   assign m1_readdata      = r_m1_readdata;
   assign m0_readdatavalid = r_m0_readdatavalid;
   assign m1_readdatavalid = r_m1_readdatavalid;

endmodule

// File: tb/tb_nios2core_gpio_arbiter.sv
// Scoreboard bench for nios2core_gpio_arbiter with a small registered-read GPIO model.
module tb_nios2core_gpio_arbiter;

   localparam logic [31:0] GMASK = 32'h0FFF_FFFF;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  m0_address, m1_address;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [1:0]  s_address;
   logic        s_chipselect, s_write_n;
   logic [31:0] s_writedata;
   logic [31:0] s_readdata;

   typedef struct packed {
      logic [1:0]  oh;
      logic [1:0]  addr;
      logic [31:0] wd;
   } slv_t;

   slv_t        exp_slv[$];
   logic [31:0] exp_rd0[$];
   logic [31:0] exp_rd1[$];
   slv_t        mon_e;
   logic [31:0] mon_d;
   int          checks = 0;
   int          errors = 0;

   logic [31:0] g_data, g_dir;

   nios2core_gpio_arbiter #(.GPIO_WIDTH(28)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
      .s_writedata(s_writedata), .s_readdata(s_readdata)
   );

   always #5 clk = ~clk;

   // GPIO model: data/direction registers, readdata registered from the address.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         g_data     <= '0;
         g_dir      <= '0;
         s_readdata <= '0;
      end else begin
         if (s_chipselect && !s_write_n) begin
            if (s_address == 2'd0) g_data <= s_writedata & GMASK;
            if (s_address == 2'd1) g_dir  <= s_writedata & GMASK;
         end
         case (s_address)
            2'd0:    s_readdata <= g_data;
            2'd1:    s_readdata <= g_dir;
            default: s_readdata <= '0;
         endcase
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops an expectation for every slave write cycle and every readdatavalid.
   always @(negedge clk) begin
      if (reset_n) begin
         if (s_chipselect && !s_write_n) begin
            chk("slv_expected", 64'(exp_slv.size() != 0), 64'(1));
            if (exp_slv.size() != 0) begin
               mon_e = exp_slv.pop_front();
               chk("slv_write", 64'({~m1_waitrequest, ~m0_waitrequest, s_address, s_writedata}),
                   64'(mon_e));
            end
         end
         if (m0_readdatavalid) begin
            chk("rd0_expected", 64'(exp_rd0.size() != 0), 64'(1));
            if (exp_rd0.size() != 0) begin
               mon_d = exp_rd0.pop_front();
               chk("rd0_data", 64'(m0_readdata), 64'(mon_d));
            end
         end
         if (m1_readdatavalid) begin
            chk("rd1_expected", 64'(exp_rd1.size() != 0), 64'(1));
            if (exp_rd1.size() != 0) begin
               mon_d = exp_rd1.pop_front();
               chk("rd1_data", 64'(m1_readdata), 64'(mon_d));
            end
         end
      end
   end

   // One master transaction; ea/ed are the expected slave address/data (or read data).
   task automatic m_xfer(input int p, input bit wr, input logic [1:0] a, input logic [31:0] d,
                         input logic [1:0] ea, input logic [31:0] ed, input int lat, input bit push);
      int  n;
      bit  done;
      logic [1:0] oh;
      oh = (p == 0) ? 2'b01 : 2'b10;
      if (push) begin
         if (wr)          exp_slv.push_back('{oh: oh, addr: ea, wd: ed});
         else if (p == 0) exp_rd0.push_back(ed);
         else             exp_rd1.push_back(ed);
      end
      if (p == 0) begin
         m0_address = a; m0_write = wr; m0_read = !wr; m0_writedata = d;
      end else begin
         m1_address = a; m1_write = wr; m1_read = !wr; m1_writedata = d;
      end
      n = 0;
      done = 1'b0;
      while (!done && n < 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (p == 0 ? !m0_waitrequest : !m1_waitrequest) done = 1'b1;
      end
      if (!done) chk("accept_timeout", 64'(n), 64'(0));
      else if (lat >= 0) chk(wr ? "write_latency" : "read_latency", 64'(n), 64'(lat));
      @(posedge clk);
      #1;
      if (p == 0) begin m0_read = 1'b0; m0_write = 1'b0; end
      else        begin m1_read = 1'b0; m1_write = 1'b0; end
      if (!wr && done) begin
         @(negedge clk);
         chk("rdv_pulse", 64'(p == 0 ? m0_readdatavalid : m1_readdatavalid), 64'(1));
         chk("rdv_other", 64'(p == 0 ? m1_readdatavalid : m0_readdatavalid), 64'(0));
      end
   endtask

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      logic seen;
      m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0;
      m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cs",    64'(s_chipselect), 64'(0));
      chk("rst_wn",    64'(s_write_n), 64'(1));
      chk("rst_addr",  64'(s_address), 64'(0));
      chk("rst_wd",    64'(s_writedata), 64'(0));
      chk("rst_wait",  64'({m1_waitrequest, m0_waitrequest}), 64'(3));
      chk("rst_rdv",   64'({m1_readdatavalid, m0_readdatavalid}), 64'(0));
      chk("rst_rdata", 64'({m1_readdata, m0_readdata}), 64'(0));
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Single write, single read, read latency and data routing.
      m_xfer(0, 1'b1, 2'd1, 32'h0000_00FF, 2'd1, 32'h0000_00FF, 1, 1'b1);
      m_xfer(0, 1'b1, 2'd0, 32'h0ABC_DEF0, 2'd0, 32'h0ABC_DEF0, 1, 1'b1);
      m_xfer(1, 1'b0, 2'd0, 32'h0,         2'd0, 32'h0ABC_DEF0, 2, 1'b1);

      // Both masters writing continuously: grants alternate starting with m0.
      for (int i = 0; i < 3; i++) begin
         exp_slv.push_back('{oh: 2'b01, addr: 2'd1, wd: 32'h100 + 32'(i)});
         exp_slv.push_back('{oh: 2'b10, addr: 2'd1, wd: 32'h200 + 32'(i)});
      end
      fork
         begin
            for (int i = 0; i < 3; i++)
               m_xfer(0, 1'b1, 2'd1, 32'h100 + 32'(i), 2'd1, 32'h0, -1, 1'b0);
         end
         begin
            for (int j = 0; j < 3; j++)
               m_xfer(1, 1'b1, 2'd1, 32'h200 + 32'(j), 2'd1, 32'h0, -1, 1'b0);
         end
      join

      // Reset while m0's read sits in RD_DATA.
      @(posedge clk);
      #1;
      m0_address = 2'd1; m0_read = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (m0_waitrequest && n < 20);
      chk("t4_reach_rd_data", 64'(n), 64'(3));
      #2;
      reset_n = 1'b0;
      #1;
      chk("t4_wait",  64'({m1_waitrequest, m0_waitrequest}), 64'(3));
      chk("t4_cs_wn", 64'({s_chipselect, s_write_n}), 64'(1));
      chk("t4_addr_wd", 64'({s_address, s_writedata}), 64'(0));
      chk("t4_rdata", 64'({m1_readdata, m0_readdata}), 64'(0));
      m0_read = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         seen = seen | m0_readdatavalid | m1_readdatavalid;
      end
      chk("t4_no_rdv", 64'(seen), 64'(0));
      @(posedge clk);
      #1;
      exp_slv.push_back('{oh: 2'b01, addr: 2'd1, wd: 32'h0000_005A});
      exp_slv.push_back('{oh: 2'b10, addr: 2'd1, wd: 32'h0000_00C3});
      fork
         m_xfer(0, 1'b1, 2'd1, 32'h0000_005A, 2'd1, 32'h0, 1, 1'b0);
         m_xfer(1, 1'b1, 2'd1, 32'h0000_00C3, 2'd1, 32'h0, -1, 1'b0);
      join
      m_xfer(0, 1'b0, 2'd1, 32'h0, 2'd1, 32'h0000_00C3, 2, 1'b1);

`ifdef NIOS2CORE_GPIO_ARB_BITOP_EN
      // Atomic set/clear through the shadow, then a shadow read-back.
      m_xfer(0, 1'b1, 2'd0, 32'h0000_000F, 2'd0, 32'h0000_000F, 1, 1'b1);
      m_xfer(1, 1'b1, 2'd2, 32'h0000_0030, 2'd0, 32'h0000_003F, 1, 1'b1);
      m_xfer(0, 1'b1, 2'd3, 32'h0000_0005, 2'd0, 32'h0000_003A, 1, 1'b1);
      m_xfer(1, 1'b0, 2'd2, 32'h0,         2'd0, 32'h0000_003A, 2, 1'b1);
`else
      // Alias addresses pass straight through to the slave.
      m_xfer(0, 1'b1, 2'd2, 32'h0000_0030, 2'd2, 32'h0000_0030, 1, 1'b1);
      m_xfer(0, 1'b0, 2'd2, 32'h0,         2'd2, 32'h0000_0000, 2, 1'b1);
`endif

      repeat (3) @(negedge clk);
      chk("slv_queue_drained", 64'(exp_slv.size()), 64'(0));
      chk("rd_queues_drained", 64'(exp_rd0.size() + exp_rd1.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
